// File: rtl/mdu_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
package mdu_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned MUL_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF = 10;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_MADD  = 3'b110,
        OP_MSUB  = 3'b111
    } op_e;

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational product, quotient and remainder from the latched operands.
module mdu_arith
    import mdu_pkg::*;
(
    input  op_e               op,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [2*XLEN-1:0] prod,
    output logic [XLEN-1:0]   quo,
    output logic [XLEN-1:0]   rem,
    output logic              div_zero
);

    logic              mul_signed;
    logic              div_signed;
    logic [2*XLEN-1:0] a_ext;
    logic [2*XLEN-1:0] b_ext;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN-1:0]   b_safe;
    logic [XLEN-1:0]   q_mag;
    logic [XLEN-1:0]   r_mag;

    // Low 64 bits of the extended-operand product give the signed or unsigned result.
    always_comb begin
        mul_signed = (op != OP_MULTU);
        a_ext      = mul_signed ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
        b_ext      = mul_signed ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
        prod       = a_ext * b_ext;
    end

    // Magnitude divide then re-sign; this also makes 0x80000000 / -1 wrap cleanly.
    always_comb begin
        div_signed = (op == OP_DIV);
        div_zero   = (b == '0);
        a_neg      = div_signed & a[XLEN-1];
        b_neg      = div_signed & b[XLEN-1];
        a_mag      = a_neg ? (~a + XLEN'(1)) : a;
        b_mag      = b_neg ? (~b + XLEN'(1)) : b;
        b_safe     = div_zero ? XLEN'(1) : b_mag;
        q_mag      = a_mag / b_safe;
        r_mag      = a_mag % b_safe;
        quo        = (a_neg ^ b_neg) ? (~q_mag + XLEN'(1)) : q_mag;
        rem        = a_neg ? (~r_mag + XLEN'(1)) : r_mag;
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative-latency HI/LO multiply/divide unit with pipeline stall generation.
// Define MDU_MADD_EN to enable the madd/msub accumulate operations.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            Start,
    input  logic [2:0]      Op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            MdUse,
    output logic            Busy,
    output logic            Stall,
    output logic [XLEN-1:0] HI,
    output logic [XLEN-1:0] LO
);

`ifdef MDU_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    op_e               op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   hi_d, lo_d;
    logic              busy_d;
    op_e               op_in;
    logic              starts_run;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] hilo;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic              div_zero;

    mdu_arith u_arith (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .prod     (prod),
        .quo      (quo),
        .rem      (rem),
        .div_zero (div_zero)
    );

    assign op_in      = op_e'(Op);
    assign hilo       = {HI, LO};
    assign starts_run = (op_in inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) ||
                        (MADD_EN && (op_in inside {OP_MADD, OP_MSUB}));

    // Stall must see the issue cycle itself, so it cannot wait for Busy.
    assign Stall = MdUse & (Busy | Start);

    // Next-state, operand latch and HI/LO update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = HI;
        lo_d    = LO;
        busy_d  = Busy;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if (op_in == OP_MTHI) begin
                        hi_d = A;
                    end else if (op_in == OP_MTLO) begin
                        lo_d = A;
                    end else if (starts_run) begin
                        op_d    = op_in;
                        a_d     = A;
                        b_d     = B;
                        cnt_d   = op_is_div(op_in) ? DIV_CNT : MUL_CNT;
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    case (op_q)
                        OP_MULT, OP_MULTU: {hi_d, lo_d} = prod;
                        OP_MADD:           {hi_d, lo_d} = hilo + prod;
                        OP_MSUB:           {hi_d, lo_d} = hilo - prod;
                        OP_DIV, OP_DIVU: begin
                            if (!div_zero) begin
                                hi_d = rem;
                                lo_d = quo;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and architectural registers; reset discards any in-flight operation.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            HI      <= '0;
            LO      <= '0;
            Busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            HI      <= hi_d;
            LO      <= lo_d;
            Busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO queued at issue, checked on completion.
module tb_mult_div_unit;

`ifdef MDU_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        Start = 1'b0;
    logic [2:0]  Op = 3'b000;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        MdUse = 1'b0;
    logic        Busy;
    logic        Stall;
    logic [31:0] HI;
    logic [31:0] LO;

    logic [63:0] sb[$];
    logic [63:0] hilo_m = '0;
    int          passed = 0;
    int          total = 0;

    mult_div_unit #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .Start (Start),
        .Op    (Op),
        .A     (A),
        .B     (B),
        .MdUse (MdUse),
        .Busy  (Busy),
        .Stall (Stall),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 CLK = ~CLK;

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] cur);
        longint      sa, sb_, q, r;
        logic [63:0] ps, pu, qv, rv;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ps  = 64'(sa * sb_);
        pu  = {32'b0, a} * {32'b0, b};
        case (op)
            3'b000: return ps;
            3'b001: return pu;
            3'b010: begin
                if (b == 0) return cur;
                q = sa / sb_;
                r = sa % sb_;
                qv = 64'(q);
                rv = 64'(r);
                return {rv[31:0], qv[31:0]};
            end
            3'b011: return (b == 0) ? cur : {a % b, a / b};
            3'b100: return {a, cur[31:0]};
            3'b101: return {cur[63:32], a};
            3'b110: return MADD_EN ? cur + ps : cur;
            default: return MADD_EN ? cur - ps : cur;
        endcase
    endfunction

    // Called one time unit after a posedge; returns one time unit after the start edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        hilo_m = model(op, a, b, hilo_m);
        sb.push_back(hilo_m);
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        @(posedge CLK); #1;
        Start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (Busy === 1'b1 && n < 40) begin
            @(posedge CLK); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        total++;
        if ({Busy, Stall, HI, LO} !== 66'd0) $display("FAIL reset: busy=%b stall=%b hi=%h lo=%h want all 0", Busy, Stall, HI, LO);
        else passed++;
        RESET = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_mult;
        int n;
        logic [63:0] e;
        issue(3'b000, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n);
        total++;
        if (n !== 5) $display("FAIL mult_busy: got %0d cycles want 5", n);
        else passed++;
        e = sb.pop_front();
        total++;
        if ({HI, LO} !== e || {HI, LO} !== 64'hFFFF_FFFF_FFFF_FFFA) $display("FAIL mult_result: got %h want %h", {HI, LO}, e);
        else passed++;
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(n);
        e = sb.pop_front();
        total++;
        if (n !== 5 || {HI, LO} !== e) $display("FAIL multu: got %h after %0d cycles want %h after 5", {HI, LO}, n, e);
        else passed++;
    endtask

    task automatic test_div;
        int n;
        logic [63:0] e;
        issue(3'b011, 32'd100, 32'd7);
        wait_idle(n);
        total++;
        if (n !== 10) $display("FAIL divu_busy: got %0d cycles want 10", n);
        else passed++;
        e = sb.pop_front();
        total++;
        if ({HI, LO} !== e || HI !== 32'd2 || LO !== 32'd14) $display("FAIL divu_result: got %h want %h", {HI, LO}, e);
        else passed++;
        issue(3'b010, -32'sd7, 32'd2);
        wait_idle(n);
        e = sb.pop_front();
        total++;
        if ({HI, LO} !== e || {HI, LO} !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL div_signed: got %h want %h", {HI, LO}, e);
        else passed++;
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        e = sb.pop_front();
        total++;
        if ({HI, LO} !== e || {HI, LO} !== 64'h0000_0000_8000_0000) $display("FAIL div_overflow: got %h want %h", {HI, LO}, e);
        else passed++;
    endtask

    task automatic test_div_zero;
        int n;
        logic [63:0] e;
        issue(3'b100, 32'd5, 32'd0);
        e = sb.pop_front();
        total++;
        if (HI !== e[63:32] || Busy !== 1'b0) $display("FAIL mthi5: got hi=%h busy=%b want hi=%h busy=0", HI, Busy, e[63:32]);
        else passed++;
        issue(3'b101, 32'd6, 32'd0);
        e = sb.pop_front();
        total++;
        if (LO !== e[31:0]) $display("FAIL mtlo6: got lo=%h want %h", LO, e[31:0]);
        else passed++;
        issue(3'b010, 32'd1234, 32'd0);
        wait_idle(n);
        e = sb.pop_front();
        total++;
        if (n !== 10 || {HI, LO} !== e || {HI, LO} !== 64'h5_0000_0006) $display("FAIL div_zero: got %h after %0d cycles want %h after 10", {HI, LO}, n, e);
        else passed++;
    endtask

    task automatic test_stall;
        int n;
        logic [63:0] e;
        hilo_m = model(3'b000, 32'd9, 32'd11, hilo_m);
        sb.push_back(hilo_m);
        Start = 1'b1; Op = 3'b000; A = 32'd9; B = 32'd11; MdUse = 1'b1;
        @(negedge CLK);
        total++;
        if (Stall !== 1'b1) $display("FAIL stall_issue: got %b want 1", Stall);
        else passed++;
        @(posedge CLK); #1;
        Start = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (Stall === 1'b1) n++;
        end
        total++;
        if (n !== 5 || Stall !== 1'b0) $display("FAIL stall_run: got %0d stalled cycles stall=%b want 5 and 0", n, Stall);
        else passed++;
        e = sb.pop_front();
        total++;
        if ({HI, LO} !== e) $display("FAIL stall_result: got %h want %h", {HI, LO}, e);
        else passed++;
        MdUse = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_start_while_run;
        int n;
        logic [63:0] e;
        issue(3'b000, 32'd7, 32'd6);
        Start = 1'b1; Op = 3'b100; A = 32'hDEAD_BEEF;
        @(posedge CLK); #1;
        Start = 1'b0;
        wait_idle(n);
        e = sb.pop_front();
        total++;
        if (n !== 4 || {HI, LO} !== e) $display("FAIL start_in_run: got %h after %0d more cycles want %h after 4", {HI, LO}, n, e);
        else passed++;
    endtask

    task automatic test_back_to_back;
        int n;
        logic [63:0] e;
        issue(3'b011, 32'hFFFF_FFFF, 32'd16);
        wait_idle(n);
        e = sb.pop_front();
        total++;
        if (n !== 10 || {HI, LO} !== e) $display("FAIL b2b_first: got %h after %0d want %h after 10", {HI, LO}, n, e);
        else passed++;
        issue(3'b000, 32'h8000_0000, 32'h8000_0000);
        wait_idle(n);
        e = sb.pop_front();
        total++;
        if (n !== 5 || {HI, LO} !== e) $display("FAIL b2b_second: got %h after %0d want %h after 5", {HI, LO}, n, e);
        else passed++;
    endtask

    task automatic test_madd;
        int n;
        logic [63:0] e;
        issue(3'b100, 32'd0, 32'd0);
        issue(3'b101, 32'd1, 32'd0);
        sb.delete();
        issue(3'b110, 32'd2, 32'd3);
        wait_idle(n);
        e = sb.pop_front();
        total++;
        if (n !== (MADD_EN ? 5 : 0) || {HI, LO} !== e || LO !== (MADD_EN ? 32'd7 : 32'd1)) $display("FAIL madd: got %h after %0d want %h", {HI, LO}, n, e);
        else passed++;
        issue(3'b111, 32'hFFFF_FFFF, 32'd4);
        wait_idle(n);
        e = sb.pop_front();
        total++;
        if (n !== (MADD_EN ? 5 : 0) || {HI, LO} !== e) $display("FAIL msub: got %h after %0d want %h", {HI, LO}, n, e);
        else passed++;
    endtask

    task automatic test_reset_mid_run;
        issue(3'b011, 32'd1000, 32'd3);
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        sb.delete();
        hilo_m = '0;
        total++;
        if ({Busy, HI, LO} !== 65'd0) $display("FAIL reset_mid_run: busy=%b hi=%h lo=%h want 0", Busy, HI, LO);
        else passed++;
        Start = 1'b1; Op = 3'b100; A = 32'h99;
        @(posedge CLK); #1;
        Start = 1'b0;
        total++;
        if (HI !== 32'd0) $display("FAIL reset_over_start: got hi=%h want 0", HI);
        else passed++;
        RESET = 1'b0;
        @(posedge CLK); #1;
        issue(3'b100, 32'h1234, 32'd0);
        total++;
        if (HI !== 32'h1234 || LO !== 32'd0 || Busy !== 1'b0) $display("FAIL mthi_after_reset: got hi=%h lo=%h busy=%b want 1234 0 0", HI, LO, Busy);
        else passed++;
        void'(sb.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_stall();
        test_start_while_run();
        test_back_to_back();
        test_madd();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter MUL_LAT, default 5, meaning the multiply busy-cycle count.
REQ-002 The block SHALL have parameter DIV_LAT, default 10, meaning the divide busy-cycle count.
REQ-003 CLK  in  1  clock; all state changes on posedge CLK.
REQ-004 RESET  in  1  reset, synchronous, active-high.
REQ-005 Start  in  1  one-cycle issue pulse from E stage.
REQ-006 Op  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 madd, 111 msub.
REQ-007 A, B  in  32 each  forwarded E-stage operands (rs, rt).
REQ-008 MdUse  in  1  E-stage instruction is mfhi/mflo/mthi/mtlo/mult/div family.
REQ-009 Busy  out  1  operation in progress.
REQ-010 Stall  out  1  freeze F/D/E, bubble M.
REQ-011 HI, LO  out  32 each  architectural HI/LO registers.

Function
REQ-012 States: IDLE, RUN; 4-bit down-counter Cnt; operands and Op latched on accepted Start.
REQ-013 Start in IDLE with Op 000-011/110/111: latch, Cnt=MUL_LAT (mult family) or DIV_LAT (div), go RUN, Busy=1 next cycle.
REQ-014 Start in IDLE with Op 100/101: HI or LO = A at next edge, no RUN, Busy stays 0.
REQ-015 Start while RUN: ignored entirely (hazard unit prevents it).
REQ-016 RUN: Cnt decrements each cycle; on Cnt==1, HI/LO written with result at that edge, state IDLE, Busy=0.
REQ-017 Result visible on HI/LO exactly MUL_LAT/DIV_LAT cycles after the Start edge.
REQ-018 Stall = MdUse & (Busy | Start), combinational; Start cycle itself stalls a following MdUse instruction.
REQ-019 mult/madd/msub signed 64-bit product; multu unsigned; {HI,LO}=product, or {HI,LO}+/-product (wrap mod 2^64).
REQ-020 div signed: LO quotient truncated toward zero, HI remainder with sign of dividend; divu unsigned.
REQ-021 Divisor zero: HI, LO unchanged, full DIV_LAT busy still spent.
REQ-022 div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
REQ-023 HI/LO change only on REQ-014/REQ-016 events.

Reset
REQ-024 RESET: state IDLE, Cnt=0, Busy=0, HI=0, LO=0, latched operands 0.
REQ-025 RESET mid-RUN aborts; no partial result written; RESET overrides simultaneous Start.

Configuration
REQ-026 Macro MDU_MADD_EN defined: Op 110/111 execute as REQ-019.
REQ-027 MDU_MADD_EN undefined: Op 110/111 treated as no-op, Start ignored, Busy stays 0.

Structure
REQ-028 Package mdu_pkg SHALL hold Op encodings and MUL_LAT/DIV_LAT defaults.
REQ-029 One sub-module mdu_arith: combinational product/quotient/remainder from latched operands and Op.

Verification
REQ-030 mult A=0xFFFFFFFE B=3 -> after 5 cycles HI=0xFFFFFFFF LO=0xFFFFFFFA, Busy high 5 cycles.
REQ-031 divu A=100 B=7 -> after 10 cycles LO=14 HI=2; div A=-7 B=2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF.
REQ-032 div B=0 with HI=5 LO=6 -> Busy 10 cycles, HI=5 LO=6 after.
REQ-033 mult then mflo next cycle (MdUse=1) -> Stall high 6 cycles, low after LO valid.
REQ-034 RESET at cycle 3 of div -> Busy=0, HI=LO=0 next cycle; mthi A=0x1234 -> HI=0x1234 one edge later.
REQ-035 MDU_MADD_EN on: HI=0 LO=1, madd A=2 B=3 -> LO=7; off: LO stays 1.
